vga_capture: RTL

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// vga_capture: captures the active area of a VGA stream into a pixel write
// port, tracks line/frame geometry and reports per-frame lock status.
// Ports:
//   CLOCK_PIX, reset      pixel clock, synchronous active-high reset
//   enable                capture enable, sampled at each frame start
//   VGA_HS/VS/BLANK_N/RGB incoming video timing and colour
//   wr_en/wr_x/wr_y/      pixel write strobe, coordinates and {R,G,B}
//   wr_data
//   frame_done/count      end-of-captured-frame pulse and frame counter
//   line_err/frame_err    sticky geometry errors
//   locked                last captured frame had the expected geometry
module vga_capture #(
   parameter int   H_ACTIVE = 640,
   parameter int   V_ACTIVE = 480,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        CLOCK_PIX,
   input  logic        reset,
   input  logic        enable,
   input  logic        VGA_HS,
   input  logic        VGA_VS,
   input  logic        VGA_BLANK_N,
   input  logic [7:0]  VGA_R,
   input  logic [7:0]  VGA_G,
   input  logic [7:0]  VGA_B,
   output logic        wr_en,
   output logic [9:0]  wr_x,
   output logic [9:0]  wr_y,
   output logic [23:0] wr_data,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output logic        line_err,
   output logic        frame_err,
   output logic        locked
);

   localparam logic [10:0] H_END = 11'(H_ACTIVE);
   localparam logic [10:0] V_END = 11'(V_ACTIVE);

   typedef enum logic [1:0] {WAIT_VS, SYNC, ACTIVE, SKIP} state_t;

   // S1 input register plus one cycle of history for edge detection
   logic        hs_q, vs_q, vs_prev_q, blank_q, blank_prev_q;
   logic [23:0] rgb_q;

   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic        lerr_frame_q, lerr_frame_d;
   logic        wr_en_q, wr_en_d;
   logic [9:0]  wr_x_q, wr_x_d, wr_y_q, wr_y_d;
   logic [23:0] wr_data_q, wr_data_d;
   logic        frame_done_q, frame_done_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        line_err_q, line_err_d;
   logic        frame_err_q, frame_err_d;
   logic        locked_q, locked_d;

   logic        vs_edge, pix_ok, y_short;
   logic [9:0]  x_inc, y_inc;
   state_t      start_st;

   // HS is registered with the rest of S1 but capture keys off BLANK_N/VS
   logic        unused_hs;
   assign unused_hs = hs_q;

   always_ff @(posedge CLOCK_PIX) begin
      if (reset) begin
         hs_q         <= ~SYNC_POL;
         vs_q         <= ~SYNC_POL;
         vs_prev_q    <= ~SYNC_POL;
         blank_q      <= 1'b0;
         blank_prev_q <= 1'b0;
         rgb_q        <= 24'h0;
      end else begin
         hs_q         <= VGA_HS;
         vs_q         <= VGA_VS;
         vs_prev_q    <= vs_q;
         blank_q      <= VGA_BLANK_N;
         blank_prev_q <= blank_q;
         rgb_q        <= {VGA_R, VGA_G, VGA_B};
      end
   end

   assign vs_edge  = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);
   assign pix_ok   = ({1'b0, x_q} < H_END) && ({1'b0, y_q} < V_END);
   assign x_inc    = (x_q == 10'h3FF) ? x_q : x_q + 10'd1;
   assign y_inc    = (y_q == 10'h3FF) ? y_q : y_q + 10'd1;
   assign y_short  = ({1'b0, y_q} != V_END);
   assign start_st = enable ? SYNC : SKIP;

   always_ff @(posedge CLOCK_PIX) begin
      if (reset) begin
         state_q       <= WAIT_VS;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         lerr_frame_q  <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_x_q        <= 10'd0;
         wr_y_q        <= 10'd0;
         wr_data_q     <= 24'h0;
         frame_done_q  <= 1'b0;
         frame_count_q <= 16'd0;
         line_err_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         lerr_frame_q  <= lerr_frame_d;
         wr_en_q       <= wr_en_d;
         wr_x_q        <= wr_x_d;
         wr_y_q        <= wr_y_d;
         wr_data_q     <= wr_data_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         line_err_q    <= line_err_d;
         frame_err_q   <= frame_err_d;
         locked_q      <= locked_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      lerr_frame_d  = lerr_frame_q;
      wr_en_d       = 1'b0;
      wr_x_d        = wr_x_q;
      wr_y_d        = wr_y_q;
      wr_data_d     = wr_data_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      line_err_d    = line_err_q;
      frame_err_d   = frame_err_q;
      locked_d      = locked_q;

      unique case (state_q)
         WAIT_VS, SKIP: begin
            if (vs_edge) begin
               state_d      = start_st;
               x_d          = 10'd0;
               y_d          = 10'd0;
               lerr_frame_d = 1'b0;
            end
         end
         SYNC, ACTIVE: begin
            if (vs_edge) begin
               // Frame end wins over a coincident active pixel.
               // A frame ending in SYNC saw no active lines (y=0).
               if (y_short || state_q == SYNC) begin
                  frame_err_d = 1'b1;
                  locked_d    = 1'b0;
               end else begin
                  locked_d    = ~lerr_frame_q;
               end
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = start_st;
               x_d           = 10'd0;
               y_d           = 10'd0;
               lerr_frame_d  = 1'b0;
            end else if (blank_q) begin
               // x/y are zero on entry to SYNC, so the first pixel is (0,0)
               state_d = ACTIVE;
               if (pix_ok) begin
                  wr_en_d   = 1'b1;
                  wr_x_d    = x_q;
                  wr_y_d    = y_q;
                  wr_data_d = rgb_q;
               end
               x_d = x_inc;
            end else if (state_q == ACTIVE && blank_prev_q) begin
               if ({1'b0, x_q} != H_END) begin
                  line_err_d   = 1'b1;
                  lerr_frame_d = 1'b1;
                  locked_d     = 1'b0;
               end
               x_d = 10'd0;
               y_d = y_inc;
            end
         end
      endcase
   end

   assign wr_en       = wr_en_q;
   assign wr_x        = wr_x_q;
   assign wr_y        = wr_y_q;
   assign wr_data     = wr_data_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign line_err    = line_err_q;
   assign frame_err   = frame_err_q;
   assign locked      = locked_q;

endmodule
